// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and types for the regfile_param slice.
//   DEF_DATA_W   : default register width
//   DEF_ADDR_W   : default index width (depth = 2**ADDR_W)
//   DEF_RA_IDX   : default index of the link ($ra) register
//   DEF_SP_IDX   : default index of the stack pointer ($sp) register
//   DEF_SP_INIT  : default $sp reset value (all ones)
//   cmp_flags_t  : latched unsigned compare flags
package regfile_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;
  localparam int DEF_RA_IDX = 3;
  localparam int DEF_SP_IDX = 2;
  localparam logic [DEF_DATA_W-1:0] DEF_SP_INIT = '1;

  typedef struct packed {
    logic slt_ab;
    logic slt_ba;
    logic eq;
  } cmp_flags_t;

endpackage

// File: rtl/regfile_sp_ctrl.sv
// regfile_sp_ctrl: next-value logic for the $sp register plus the sticky
// wrap-around flag.
// Priority on $sp: link write > general write > push/pop.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   sp_cur        : current stored $sp
//   push, pop     : decrement / increment requests (both together cancel)
//   wr_en, wr_data: general write aimed at $sp
//   link_en, link_data : link write aimed at $sp (only if RA_IDX == SP_IDX)
//   sp_next       : value $sp takes on the next rising edge
//   sp_err        : sticky wrap indicator, cleared only by reset
module regfile_sp_ctrl #(
  parameter int DATA_W = regfile_pkg::DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sp_cur,
  input  logic              push,
  input  logic              pop,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              link_en,
  input  logic [DATA_W-1:0] link_data,
  output logic [DATA_W-1:0] sp_next,
  output logic              sp_err
);

  logic sp_err_d, sp_err_q;
  logic wrap;

  always_comb begin
    sp_next = sp_cur;
    wrap    = 1'b0;
    if (link_en) begin
      sp_next = link_data;
    end else if (wr_en) begin
      sp_next = wr_data;
    end else if (push && !pop) begin
      sp_next = sp_cur - 1'b1;
      wrap    = (sp_cur == '0);
    end else if (pop && !push) begin
      sp_next = sp_cur + 1'b1;
      wrap    = (sp_cur == '1);
    end
    sp_err_d = sp_err_q | wrap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sp_err_q <= 1'b0;
    else       sp_err_q <= sp_err_d;
  end

  assign sp_err = sp_err_q;

endmodule

// File: rtl/regfile_param.sv
// regfile_param: parameterised register file with link ($ra) write port,
// stack-pointer ($sp) push/pop, and latched unsigned compare flags.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data to the read ports (link > we > stack priority).
// Ports:
//   clk, reset            : clock (rising), asynchronous active-high reset
//   we, waddr, wdata      : general write port
//   raddr_a/b, rdata_a/b  : combinational read ports
//   link_we, link_data    : jal link write into RA_IDX (beats we)
//   sp_push, sp_pop       : $sp decrement / increment
//   cmp_en                : latch slt_ab / slt_ba / eq from rdata_a vs rdata_b
//   ra_out, sp_out        : views of the $ra / $sp registers
//   sp_err                : sticky $sp wrap indicator
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int RA_IDX = DEF_RA_IDX,
  parameter int SP_IDX = DEF_SP_IDX,
  parameter logic [DATA_W-1:0] SP_INIT = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              link_we,
  input  logic [DATA_W-1:0] link_data,
  input  logic              sp_push,
  input  logic              sp_pop,
  input  logic              cmp_en,
  output logic              slt_ab,
  output logic              slt_ba,
  output logic              eq,
  output logic [DATA_W-1:0] ra_out,
  output logic [DATA_W-1:0] sp_out,
  output logic              sp_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] RA_A = ADDR_W'(RA_IDX);
  localparam logic [ADDR_W-1:0] SP_A = ADDR_W'(SP_IDX);

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DATA_W-1:0] sp_next;
  cmp_flags_t        flags_d, flags_q;

  regfile_sp_ctrl #(.DATA_W(DATA_W)) u_sp_ctrl (
    .clk       (clk),
    .reset     (reset),
    .sp_cur    (regs_q[SP_A]),
    .push      (sp_push),
    .pop       (sp_pop),
    .wr_en     (we && (waddr == SP_A)),
    .wr_data   (wdata),
    .link_en   (link_we && (RA_A == SP_A)),
    .link_data (link_data),
    .sp_next   (sp_next),
    .sp_err    (sp_err)
  );

  // Next array image. The $sp slot always takes sp_next, which already
  // folds in the general and link writes aimed at it; link is applied last
  // so it beats a same-cycle general write to RA_IDX.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) regs_d[i] = regs_q[i];
    if (we) regs_d[waddr] = wdata;
    regs_d[SP_A] = sp_next;
    if (link_we) regs_d[RA_A] = link_data;
  end

`ifdef REGFILE_BYPASS_EN
  // regs_d equals regs_q for every slot not being written this cycle.
  assign rdata_a = regs_d[raddr_a];
  assign rdata_b = regs_d[raddr_b];
`else
  assign rdata_a = regs_q[raddr_a];
  assign rdata_b = regs_q[raddr_b];
`endif

  always_comb begin
    flags_d = flags_q;
    if (cmp_en) begin
      flags_d.slt_ab = (rdata_a < rdata_b);
      flags_d.slt_ba = (rdata_b < rdata_a);
      flags_d.eq     = (rdata_a == rdata_b);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
      flags_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      flags_q <= flags_d;
    end
  end

  assign slt_ab = flags_q.slt_ab;
  assign slt_ba = flags_q.slt_ba;
  assign eq     = flags_q.eq;
  assign ra_out = regs_q[RA_A];
  assign sp_out = regs_q[SP_A];

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param at default parameters.
module tb_regfile_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       we;
  logic [1:0] waddr;
  logic [7:0] wdata;
  logic [1:0] raddr_a, raddr_b;
  logic [7:0] rdata_a, rdata_b;
  logic       link_we;
  logic [7:0] link_data;
  logic       sp_push, sp_pop, cmp_en;
  logic       slt_ab, slt_ba, eq;
  logic [7:0] ra_out, sp_out;
  logic       sp_err;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  regfile_param dut (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
    .link_we(link_we), .link_data(link_data), .sp_push(sp_push), .sp_pop(sp_pop),
    .cmp_en(cmp_en), .slt_ab(slt_ab), .slt_ba(slt_ba), .eq(eq),
    .ra_out(ra_out), .sp_out(sp_out), .sp_err(sp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; link_we = 0; sp_push = 0; sp_pop = 0; cmp_en = 0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    we = 1; waddr = a; wdata = d;
    step();
    we = 0;
  endtask

  initial begin
    idle();
    waddr = 0; wdata = 0; raddr_a = 0; raddr_b = 1; link_data = 0;
    reset = 1;
    #2;
    // Reset state before any clock edge.
    check("rst_r0", rdata_a, 8'h00);
    check("rst_r1", rdata_b, 8'h00);
    raddr_a = 3; #1;
    check("rst_r3", rdata_a, 8'h00);
    check("rst_sp", sp_out, 8'hFF);
    check("rst_ra", ra_out, 8'h00);
    check("rst_flags", {slt_ab, slt_ba, eq}, 3'b000);
    check("rst_sperr", sp_err, 1'b0);
    step();
    reset = 0;

    // General write and read timing.
    raddr_a = 1;
    we = 1; waddr = 1; wdata = 8'h5A; #1;
`ifdef REGFILE_BYPASS_EN
    check("wr_same_cycle", rdata_a, 8'h5A);
`else
    check("wr_same_cycle", rdata_a, 8'h00);
`endif
    step(); we = 0;
    check("wr_next_cycle", rdata_a, 8'h5A);

    // link_we beats we on the $ra slot.
    we = 1; waddr = 3; wdata = 8'h11; link_we = 1; link_data = 8'hB3;
    step(); idle();
    check("link_wins", ra_out, 8'hB3);
    raddr_b = 3; #1;
    check("link_read", rdata_b, 8'hB3);

    // Compare 3 vs 7.
    wr(0, 8'h03);
    wr(1, 8'h07);
    raddr_a = 0; raddr_b = 1;
    cmp_en = 1; step(); cmp_en = 0;
    check("cmp_lt", {slt_ab, slt_ba, eq}, 3'b100);
    wr(0, 8'h42);
    wr(1, 8'h42);
    check("cmp_hold", {slt_ab, slt_ba, eq}, 3'b100);
    cmp_en = 1; step(); cmp_en = 0;
    check("cmp_eq", {slt_ab, slt_ba, eq}, 3'b001);
    wr(1, 8'h10);
    cmp_en = 1; step(); cmp_en = 0;
    check("cmp_gt", {slt_ab, slt_ba, eq}, 3'b010);

    // Stack pointer.
    wr(2, 8'h00);
    check("sp_load0", sp_out, 8'h00);
    check("sp_err_clear", sp_err, 1'b0);
    sp_push = 1; step(); sp_push = 0;
    check("sp_push_wrap", sp_out, 8'hFF);
    check("sp_err_set", sp_err, 1'b1);
    sp_push = 1; sp_pop = 1; step(); idle();
    check("sp_pushpop", sp_out, 8'hFF);
    sp_pop = 1; step(); sp_pop = 0;
    check("sp_pop_wrap", sp_out, 8'h00);
    check("sp_err_sticky", sp_err, 1'b1);
    we = 1; waddr = 2; wdata = 8'h80; sp_push = 1; step(); idle();
    check("sp_we_over", sp_out, 8'h80);
    sp_push = 1; step(); sp_push = 0;
    check("sp_push", sp_out, 8'h7F);
    sp_pop = 1; step(); sp_pop = 0;
    check("sp_pop", sp_out, 8'h80);

    // Idle cycle leaves everything alone.
    wdata = 8'hEE; waddr = 0; step();
    check("idle_r0", rdata_a, 8'h42);
    check("idle_r1", rdata_b, 8'h10);
    check("idle_ra", ra_out, 8'hB3);
    check("idle_sp", sp_out, 8'h80);

    // Mid-cycle reset with a pending write.
    we = 1; waddr = 1; wdata = 8'h99;
    #2; reset = 1; #1;
    check("rst2_r1", rdata_b, 8'h00);
    check("rst2_r0", rdata_a, 8'h00);
    check("rst2_sp", sp_out, 8'hFF);
    check("rst2_ra", ra_out, 8'h00);
    check("rst2_flags", {slt_ab, slt_ba, eq}, 3'b000);
    check("rst2_sperr", sp_err, 1'b0);
    step();
    reset = 0; we = 0; #1;
    check("rst2_dropped", rdata_b, 8'h00);
    wr(1, 8'h21);
    check("resume_wr", rdata_b, 8'h21);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    n_total++;
    $display("FAIL timeout observed=running expected=finished");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
